// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM tile engine and its layer-level scheduler:
// state encoding, array size, BRAM address widths and default tile strides.
package gemm_pkg;

    localparam int PE_SIZE          = 14;
    localparam int MEM0_ADDR_WIDTH  = 13;
    localparam int MEM1_ADDR_WIDTH  = 11;
    localparam int MEM2_ADDR_WIDTH  = 10;
    localparam int MEM0_TILE_STRIDE = 21 * PE_SIZE;
    localparam int MEM1_TILE_STRIDE = 21 * PE_SIZE;
    localparam int MEM2_TILE_STRIDE = PE_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_e;

endpackage

// File: rtl/gemm_watchdog.sv
// Cycle watchdog: counts while enabled, restarts from 0 on clear, and flags
// expiry once the counter saturates at all-ones.
module gemm_watchdog #(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TIMEOUT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
        end else if (enable && !expire) begin
            count_q <= count_q + TIMEOUT_WIDTH'(1);
        end
    end

    assign expire = &count_q;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Layer controller: walks an M x N output-tile grid (row-outer, col-inner),
// launching one GEMM tile at a time with its BRAM base addresses.
module gemm_tile_scheduler
    import gemm_pkg::*;
#(
    parameter int PE_SIZE_P        = PE_SIZE,
    parameter int MEM0_ADDR_WIDTH_P = MEM0_ADDR_WIDTH,
    parameter int MEM1_ADDR_WIDTH_P = MEM1_ADDR_WIDTH,
    parameter int MEM2_ADDR_WIDTH_P = MEM2_ADDR_WIDTH,
    parameter int MEM0_TILE_STRIDE_P = MEM0_TILE_STRIDE,
    parameter int MEM1_TILE_STRIDE_P = MEM1_TILE_STRIDE,
    parameter int MEM2_TILE_STRIDE_P = MEM2_TILE_STRIDE,
    parameter int TILE_CNT_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [TILE_CNT_WIDTH-1:0]      cfg_row_tiles_i,
    input  logic [TILE_CNT_WIDTH-1:0]      cfg_col_tiles_i,
    output logic                           tile_start_o,
    input  logic                           tile_done_i,
    output logic [MEM0_ADDR_WIDTH_P-1:0]   mem0_base_o,
    output logic [MEM1_ADDR_WIDTH_P-1:0]   mem1_base_o,
    output logic [MEM2_ADDR_WIDTH_P-1:0]   mem2_base_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_timeout_o,
    output logic [2*TILE_CNT_WIDTH-1:0]    tiles_done_o,
    output state_e                         dbg_state_o
);

    // Tile handshake: tile_start_o is a one-cycle request with the bases valid
    // from then until tile_done_i; tile_done_i is a one-cycle reply that is
    // only accepted in WAIT. Neither side can apply back-pressure.

    state_e                    state_q, state_d;
    logic [TILE_CNT_WIDTH-1:0] rows_q, cols_q, row_idx_q, col_idx_q;
    logic                      wd_expire;
    logic                      last_col, last_tile;

    assign last_col    = (col_idx_q == cols_q - TILE_CNT_WIDTH'(1));
    assign last_tile   = last_col && (row_idx_q == rows_q - TILE_CNT_WIDTH'(1));
    assign dbg_state_o = state_q;

    gemm_watchdog #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != S_WAIT),
        .enable(state_q == S_WAIT),
        .expire(wd_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (cfg_row_tiles_i == '0 || cfg_col_tiles_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT: begin
                if (tile_done_i) begin
                    state_d = S_ADVANCE;
                end else if (wd_expire) begin
                    state_d = S_DONE;
                end
            end
            S_ADVANCE: state_d = last_tile ? S_DONE : S_ISSUE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            row_idx_q     <= '0;
            col_idx_q     <= '0;
            mem0_base_o   <= '0;
            mem1_base_o   <= '0;
            mem2_base_o   <= '0;
            tile_start_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            tiles_done_o  <= '0;
        end else begin
            state_q      <= state_d;
            tile_start_o <= (state_d == S_ISSUE);
            busy_o       <= (state_d != S_IDLE);
            done_o       <= (state_d == S_DONE);
            // An abort freezes the counters; IDLE never sees abort_i.
            if (!abort_i || state_q == S_IDLE) begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            rows_q        <= cfg_row_tiles_i;
                            cols_q        <= cfg_col_tiles_i;
                            row_idx_q     <= '0;
                            col_idx_q     <= '0;
                            mem0_base_o   <= '0;
                            mem1_base_o   <= '0;
                            mem2_base_o   <= '0;
                            err_timeout_o <= 1'b0;
                            tiles_done_o  <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (tile_done_i) begin
                            tiles_done_o <= tiles_done_o + (2*TILE_CNT_WIDTH)'(1);
                        end else if (wd_expire) begin
                            err_timeout_o <= 1'b1;
                        end
                    end
                    S_ADVANCE: begin
                        mem2_base_o <= mem2_base_o + MEM2_ADDR_WIDTH_P'(MEM2_TILE_STRIDE_P);
                        if (last_col) begin
                            col_idx_q   <= '0;
                            mem1_base_o <= '0;
                            row_idx_q   <= row_idx_q + TILE_CNT_WIDTH'(1);
                            mem0_base_o <= mem0_base_o + MEM0_ADDR_WIDTH_P'(MEM0_TILE_STRIDE_P);
                        end else begin
                            col_idx_q   <= col_idx_q + TILE_CNT_WIDTH'(1);
                            mem1_base_o <= mem1_base_o + MEM1_ADDR_WIDTH_P'(MEM1_TILE_STRIDE_P);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: a tile-engine responder, a base-address
// scoreboard fed by a row-major grid model, and hand-computed layer timing.
module tb_gemm_tile_scheduler;
    import gemm_pkg::*;

    localparam int TW = 5;
    localparam int BW = MEM0_ADDR_WIDTH + MEM1_ADDR_WIDTH + MEM2_ADDR_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic         abort_i;
    logic [7:0]   cfg_row_tiles_i;
    logic [7:0]   cfg_col_tiles_i;
    logic         tile_start_o;
    logic         tile_done_i;
    logic [12:0]  mem0_base_o;
    logic [10:0]  mem1_base_o;
    logic [9:0]   mem2_base_o;
    logic         busy_o;
    logic         done_o;
    logic         err_timeout_o;
    logic [15:0]  tiles_done_o;
    state_e       dbg_state_o;

    logic [BW-1:0] exp_q[$];
    int n_vec;
    int n_err;

    gemm_tile_scheduler #(
        .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cfg_row_tiles_i(cfg_row_tiles_i),
        .cfg_col_tiles_i(cfg_col_tiles_i),
        .tile_start_o   (tile_start_o),
        .tile_done_i    (tile_done_i),
        .mem0_base_o    (mem0_base_o),
        .mem1_base_o    (mem1_base_o),
        .mem2_base_o    (mem2_base_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_timeout_o  (err_timeout_o),
        .tiles_done_o   (tiles_done_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected tile bases, row-major over the grid.
    task automatic push_grid(input int m, input int n);
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                exp_q.push_back({13'((r * MEM0_TILE_STRIDE) % 8192),
                                 11'((c * MEM1_TILE_STRIDE) % 2048),
                                 10'(((r * n + c) * MEM2_TILE_STRIDE) % 1024)});
            end
        end
    endtask

    // Runs one layer from a start pulse; answers each tile_start after dly cycles
    // (dly<=0: never). abort_tile>0 aborts during that tile's first WAIT cycle.
    task automatic run_layer(input int m, input int n, input int dly, input bit hold,
                             input int abort_tile, output int n_start, output int n_done,
                             output int done_cyc);
        int cnt;
        int post;
        int ab;
        bit ended;
        logic [BW-1:0] e;
        cnt = 0; post = -1; ab = 0; ended = 0;
        n_start = 0; n_done = 0; done_cyc = -1;
        cfg_row_tiles_i = 8'(m);
        cfg_col_tiles_i = 8'(n);
        start_i = 1'b1;
        @(negedge clk);
        if (!hold) start_i = 1'b0;
        for (int cyc = 1; cyc <= 600 && !ended; cyc++) begin
            if (cyc == 1) check("busy_rise", 32'(busy_o), 1);
            if (cyc == done_cyc + 1) check("busy_fall", 32'(busy_o), 0);
            if (tile_start_o) begin
                n_start++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("mem0_base", 32'(mem0_base_o), 32'(e[BW-1 -: 13]));
                    check("mem1_base", 32'(mem1_base_o), 32'(e[20:10]));
                    check("mem2_base", 32'(mem2_base_o), 32'(e[9:0]));
                end
                if (dly > 0) cnt = dly + 1;
                if (n_start == abort_tile) ab = 1;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
                start_i = 1'b0;
                if (post < 0) post = 3;
            end
            if (ab == 3) begin
                check("abort_busy", 32'(busy_o), 0);
                check("abort_state", 32'(dbg_state_o), 32'(S_IDLE));
                ab = 4;
                post = dly + 3;
            end
            // drive inputs for the next rising edge
            tile_done_i = 1'b0;
            abort_i = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tile_done_i = 1'b1;
            end
            if (ab == 2) begin
                abort_i = 1'b1;
                ab = 3;
            end else if (ab == 1) begin
                ab = 2;
            end
            if (post > 0) begin
                post--;
                if (post == 0) ended = 1;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        tile_done_i = 1'b0;
        abort_i = 1'b0;
        check("layer_end", 32'(ended), 1);
    endtask

    initial begin
        int ns, nd, dc;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_i = 1'b1;
        abort_i = 1'b0;
        tile_done_i = 1'b0;
        cfg_row_tiles_i = 8'd3;
        cfg_col_tiles_i = 8'd3;

        // reset with start held
        repeat (3) @(negedge clk);
        check("rst_tile_start", 32'(tile_start_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_timeout_o), 0);
        check("rst_tiles", 32'(tiles_done_o), 0);
        check("rst_bases", 32'({mem0_base_o, mem1_base_o, mem2_base_o} != '0), 0);
        start_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", 32'(dbg_state_o), 32'(S_IDLE));
        check("post_rst_busy", 32'(busy_o), 0);

        // 2 x 3 grid, 20-cycle tiles
        push_grid(2, 3);
        run_layer(2, 3, 20, 0, 0, ns, nd, dc);
        check("g23_starts", ns, 6);
        check("g23_dones", nd, 1);
        check("g23_done_cyc", dc, 6 * 22 + 1);
        check("g23_tiles", 32'(tiles_done_o), 6);
        check("g23_err", 32'(err_timeout_o), 0);
        check("g23_sb_left", exp_q.size(), 0);

        // empty grid
        run_layer(0, 5, 20, 0, 0, ns, nd, dc);
        check("g05_starts", ns, 0);
        check("g05_dones", nd, 1);
        check("g05_done_cyc", dc, 1);
        check("g05_tiles", 32'(tiles_done_o), 0);

        // watchdog expiry, then a clean layer clears the error
        push_grid(1, 1);
        run_layer(1, 1, 0, 0, 0, ns, nd, dc);
        check("to_starts", ns, 1);
        check("to_dones", nd, 1);
        check("to_done_cyc", dc, (1 << TW) + 2);
        check("to_err", 32'(err_timeout_o), 1);
        check("to_tiles", 32'(tiles_done_o), 0);
        push_grid(1, 1);
        run_layer(1, 1, 2, 0, 0, ns, nd, dc);
        check("clr_err", 32'(err_timeout_o), 0);
        check("clr_tiles", 32'(tiles_done_o), 1);
        check("clr_done_cyc", dc, 1 * 4 + 1);

        // abort in the second WAIT; the late tile_done lands in IDLE
        push_grid(1, 4);
        run_layer(1, 4, 5, 0, 2, ns, nd, dc);
        check("ab_starts", ns, 2);
        check("ab_dones", nd, 0);
        check("ab_tiles", 32'(tiles_done_o), 1);
        exp_q.delete();
        push_grid(1, 4);
        run_layer(1, 4, 3, 0, 0, ns, nd, dc);
        check("re_starts", ns, 4);
        check("re_dones", nd, 1);
        check("re_done_cyc", dc, 4 * 5 + 1);
        check("re_tiles", 32'(tiles_done_o), 4);

        // start held for the whole layer, tile_done on WAIT entry
        push_grid(2, 2);
        run_layer(2, 2, 1, 1, 0, ns, nd, dc);
        check("hold_starts", ns, 4);
        check("hold_dones", nd, 1);
        check("hold_done_cyc", dc, 4 * 3 + 1);
        check("hold_tiles", 32'(tiles_done_o), 4);
        check("hold_state", 32'(dbg_state_o), 32'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
